// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters and the memory.
// Member names carry the arbiter's direction: i_* flows into the arbiter and o_* flows out of it.
interface imem_arbiter_if #(
  parameter int ADR_W = 20
) ();
  // fetch port
  logic              i_f_req;
  logic [31:0]       i_f_adr;
  logic              o_f_gnt;
  logic              o_f_rvalid;
  logic [31:0]       o_f_instr;
  logic              o_f_err;
  // loader / debug port
  logic              i_l_req;
  logic              i_l_we;
  logic [31:0]       i_l_adr;
  logic [31:0]       i_l_wdata;
  logic              o_l_gnt;
  logic              o_l_rvalid;
  logic [31:0]       o_l_rdata;
  // boot sequencing
  logic              i_boot_done;
  logic              o_run;
  // memory side
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADR_W-1:0]  o_mem_adr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  // Arbiter view of the bundle.
  modport slave (
    input  i_f_req, i_f_adr, i_l_req, i_l_we, i_l_adr, i_l_wdata, i_boot_done, i_mem_rdata,
    output o_f_gnt, o_f_rvalid, o_f_instr, o_f_err,
    output o_l_gnt, o_l_rvalid, o_l_rdata, o_run,
    output o_mem_en, o_mem_we, o_mem_adr, o_mem_wdata
  );

  // Requester / memory-environment view of the bundle.
  modport master (
    output i_f_req, i_f_adr, i_l_req, i_l_we, i_l_adr, i_l_wdata, i_boot_done, i_mem_rdata,
    input  o_f_gnt, o_f_rvalid, o_f_instr, o_f_err,
    input  o_l_gnt, o_l_rvalid, o_l_rdata, o_run,
    input  o_mem_en, o_mem_we, o_mem_adr, o_mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-ported byte-addressed memory between the
// IF-stage fetch port and a loader/debug port. After reset only the loader may access memory
// (BOOT) until i_boot_done; in RUN fetch has priority, with a starvation guard for the loader.
// Grants and memory strobes are combinational in the request cycle; responses come one cycle later.
// Optional macro IMEM_ARB_STATS_EN adds fetch-stall and loader-grant statistics counters.
module imem_arbiter #(
  parameter int          ADR_W      = 20,
  parameter int          MAX_STARVE = 4,
  parameter bit          BOOT_HOLD  = 1'b1,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  imem_arbiter_if.slave bus
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]   o_f_stall_cnt,
  output logic [15:0]   o_l_gnt_cnt
`endif
);

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LP_MAX       = 4'(MAX_STARVE);
  localparam state_t     LP_RST_STATE = BOOT_HOLD ? S_BOOT : S_RUN;

  state_t       r_state;
  logic         r_run;
  logic [3:0]   r_starve;
  logic         r_f_rvalid;
  logic         r_f_err;
  logic         r_l_rvalid;
  logic         r_l_we;

  logic         w_f_fault;
  logic         w_starved;
  logic         w_f_gnt;
  logic         w_l_gnt;
  logic [31:0]  w_l_adr_al;

  // Saturating increment of the loader starvation counter.
  function automatic logic [3:0] starve_inc(input logic [3:0] cur);
    return (cur >= LP_MAX) ? LP_MAX : cur + 4'd1;
  endfunction

  // A fetch is faulted when misaligned or beyond the memory's byte-address range.
  assign w_f_fault  = (bus.i_f_adr[1:0] != 2'b00) || ((bus.i_f_adr >> ADR_W) != 32'd0);
  // Loader accesses are always whole words; stray low address bits are dropped.
  assign w_l_adr_al = {bus.i_l_adr[31:2], 2'b00};
  assign w_starved  = (r_starve == LP_MAX);

  // Request-cycle arbitration: loader only in BOOT; fetch first in RUN unless the loader is starved.
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (i_rst_n) begin
      if (r_state == S_BOOT) begin
        w_l_gnt = bus.i_l_req;
      end else begin
        w_l_gnt = bus.i_l_req && (w_starved || !bus.i_f_req);
        w_f_gnt = bus.i_f_req && !w_l_gnt;
      end
    end
  end

  // Drive the memory in the grant cycle; faulted fetches are granted without touching memory.
  always_comb begin
    bus.o_mem_en    = w_l_gnt || (w_f_gnt && !w_f_fault);
    bus.o_mem_we    = w_l_gnt && bus.i_l_we;
    bus.o_mem_adr   = '0;
    bus.o_mem_wdata = '0;
    if (w_l_gnt) begin
      bus.o_mem_adr = w_l_adr_al[ADR_W-1:0];
      if (bus.i_l_we) bus.o_mem_wdata = bus.i_l_wdata;
    end else if (w_f_gnt) begin
      bus.o_mem_adr = bus.i_f_adr[ADR_W-1:0];
    end
  end

  // Boot sequencer: BOOT until the done pulse, then RUN until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LP_RST_STATE;
      r_run   <= !BOOT_HOLD;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (bus.i_boot_done) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end
        end
        S_RUN: begin
          r_state <= S_RUN;
          r_run   <= 1'b1;
        end
        default: begin
          r_state <= LP_RST_STATE;
          r_run   <= !BOOT_HOLD;
        end
      endcase
    end
  end

  // Count consecutive denied loader cycles; any grant or dropped request restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= 4'd0;
    end else if (!bus.i_l_req || w_l_gnt) begin
      r_starve <= 4'd0;
    end else begin
      r_starve <= starve_inc(r_starve);
    end
  end

  // Remember who was granted so the response is routed back one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_f_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_l_we     <= 1'b0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_f_err    <= w_f_gnt && w_f_fault;
      r_l_rvalid <= w_l_gnt;
      r_l_we     <= w_l_gnt && bus.i_l_we;
    end
  end

  assign bus.o_f_gnt    = w_f_gnt;
  assign bus.o_l_gnt    = w_l_gnt;
  assign bus.o_run      = r_run;
  assign bus.o_f_rvalid = r_f_rvalid;
  assign bus.o_f_err    = r_f_err;
  assign bus.o_f_instr  = !r_f_rvalid ? 32'd0 : (r_f_err ? NOP_INSTR : bus.i_mem_rdata);
  assign bus.o_l_rvalid = r_l_rvalid;
  assign bus.o_l_rdata  = (r_l_rvalid && !r_l_we) ? bus.i_mem_rdata : 32'd0;

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] r_f_stall_cnt;
  logic [15:0] r_l_gnt_cnt;

  // Saturating 16-bit event counter step.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cur);
    return (cur == 16'hFFFF) ? cur : cur + 16'd1;
  endfunction

  // Statistics: stalled fetch cycles (BOOT included) and loader grants.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_f_stall_cnt <= 16'd0;
      r_l_gnt_cnt   <= 16'd0;
    end else begin
      if (bus.i_f_req && !w_f_gnt) r_f_stall_cnt <= sat_inc16(r_f_stall_cnt);
      if (w_l_gnt)                 r_l_gnt_cnt   <= sat_inc16(r_l_gnt_cnt);
    end
  end

  assign o_f_stall_cnt = r_f_stall_cnt;
  assign o_l_gnt_cnt   = r_l_gnt_cnt;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: table-driven per-cycle vectors with a response scoreboard,
// plus a hand-written reset-during-response sequence.
module tb_imem_arbiter;
  localparam int ADR_W = 20;

  typedef struct {
    logic        f_req;
    logic [31:0] f_adr;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_adr;
    logic [31:0] l_wdata;
    logic        boot;
    logic        e_fg;
    logic        e_lg;
    logic        e_en;
    logic        e_we;
    logic        e_run;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  vec_t        vecs[$];
  rsp_t        f_q[$];
  rsp_t        l_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] env_mem[0:1023];
  int          exp_stall;
  int          exp_lgnt;

  imem_arbiter_if #(.ADR_W(ADR_W)) bus ();

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] lgnt_cnt;
`endif

  imem_arbiter #(
    .ADR_W(ADR_W), .MAX_STARVE(4), .BOOT_HOLD(1'b1), .NOP_INSTR(32'h13)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
`ifdef IMEM_ARB_STATS_EN
    ,
    .o_f_stall_cnt(stall_cnt),
    .o_l_gnt_cnt  (lgnt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory environment: one-cycle read latency, writes land at the clock edge.
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) env_mem[bus.o_mem_adr[11:2]] <= bus.o_mem_wdata;
      bus.i_mem_rdata <= env_mem[bus.o_mem_adr[11:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic f_req, input logic [31:0] f_adr,
                              input logic l_req, input logic l_we, input logic [31:0] l_adr,
                              input logic [31:0] l_wdata, input logic boot,
                              input logic fg, input logic lg, input logic en, input logic we,
                              input logic run);
    vec_t v;
    v.f_req = f_req; v.f_adr = f_adr; v.l_req = l_req; v.l_we = l_we; v.l_adr = l_adr;
    v.l_wdata = l_wdata; v.boot = boot; v.e_fg = fg; v.e_lg = lg; v.e_en = en; v.e_we = we;
    v.e_run = run;
    return v;
  endfunction

  function automatic logic f_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0010_0000);
  endfunction

  task automatic drive_idle();
    bus.i_f_req = 1'b0; bus.i_f_adr = '0; bus.i_l_req = 1'b0; bus.i_l_we = 1'b0;
    bus.i_l_adr = '0; bus.i_l_wdata = '0; bus.i_boot_done = 1'b0;
  endtask

  // One clock cycle: drive, check last cycle's responses, check grants, queue new responses.
  task automatic apply(input vec_t v, input int idx);
    rsp_t r;
    logic [31:0] ea;
    int k;
    @(posedge clk);
    #1;
    bus.i_f_req = v.f_req; bus.i_f_adr = v.f_adr; bus.i_l_req = v.l_req; bus.i_l_we = v.l_we;
    bus.i_l_adr = v.l_adr; bus.i_l_wdata = v.l_wdata; bus.i_boot_done = v.boot;
    @(negedge clk);
    if (f_q.size() > 0) begin
      r = f_q.pop_front();
      chk($sformatf("v%0d f_rvalid", idx), 32'(bus.o_f_rvalid), 32'd1);
      chk($sformatf("v%0d f_instr", idx), bus.o_f_instr, r.data);
      chk($sformatf("v%0d f_err", idx), 32'(bus.o_f_err), 32'(r.err));
    end else begin
      chk($sformatf("v%0d f_rvalid idle", idx), 32'(bus.o_f_rvalid), 32'd0);
    end
    if (l_q.size() > 0) begin
      r = l_q.pop_front();
      chk($sformatf("v%0d l_rvalid", idx), 32'(bus.o_l_rvalid), 32'd1);
      chk($sformatf("v%0d l_rdata", idx), bus.o_l_rdata, r.data);
    end else begin
      chk($sformatf("v%0d l_rvalid idle", idx), 32'(bus.o_l_rvalid), 32'd0);
    end
    chk($sformatf("v%0d f_gnt", idx), 32'(bus.o_f_gnt), 32'(v.e_fg));
    chk($sformatf("v%0d l_gnt", idx), 32'(bus.o_l_gnt), 32'(v.e_lg));
    chk($sformatf("v%0d mem_en", idx), 32'(bus.o_mem_en), 32'(v.e_en));
    chk($sformatf("v%0d mem_we", idx), 32'(bus.o_mem_we), 32'(v.e_we));
    chk($sformatf("v%0d run", idx), 32'(bus.o_run), 32'(v.e_run));
    if (v.e_en) begin
      ea = v.e_lg ? {12'd0, v.l_adr[ADR_W-1:2], 2'b00} : {12'd0, v.f_adr[ADR_W-1:0]};
      chk($sformatf("v%0d mem_adr", idx), 32'(bus.o_mem_adr), ea);
    end
    if (v.e_we) chk($sformatf("v%0d mem_wdata", idx), bus.o_mem_wdata, v.l_wdata);
    if (v.f_req && !v.e_fg) exp_stall++;
    if (v.e_lg) exp_lgnt++;
    if (v.e_fg) begin
      r.err = f_fault(v.f_adr);
      k = int'(v.f_adr >> 2);
      r.data = r.err ? 32'h13 : (ref_mem.exists(k) ? ref_mem[k] : 32'h0);
      f_q.push_back(r);
    end
    if (v.e_lg) begin
      k = int'(v.l_adr >> 2);
      r.err = 1'b0;
      if (v.l_we) begin
        ref_mem[k] = v.l_wdata;
        r.data = 32'h0;
      end else begin
        r.data = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      end
      l_q.push_back(r);
    end
  endtask

  initial begin
    checks = 0; failures = 0; exp_stall = 0; exp_lgnt = 0;
    rst_n = 1'b0;
    drive_idle();
    bus.i_l_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst run", 32'(bus.o_run), 32'd0);
    chk("rst f_gnt", 32'(bus.o_f_gnt), 32'd0);
    chk("rst l_gnt", 32'(bus.o_l_gnt), 32'd0);
    chk("rst mem_en", 32'(bus.o_mem_en), 32'd0);
    chk("rst f_rvalid", 32'(bus.o_f_rvalid), 32'd0);
    chk("rst l_rvalid", 32'(bus.o_l_rvalid), 32'd0);
    chk("rst f_instr", bus.o_f_instr, 32'd0);
    @(posedge clk);
    #1;
    drive_idle();
    rst_n = 1'b1;

    // Phase 1: boot, first fetches, faults, misaligned loader read, starvation pattern.
    vecs.push_back(mk(1, 32'h0, 0, 0, 32'h0, 32'h0,         0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h0, 1, 1, 32'h0, 32'hDEADBEEF,  0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 32'h0, 1, 1, 32'h4, 32'h11223344,  1, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 32'h0, 0, 0, 32'h0, 32'h0,         0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 32'h4, 0, 0, 32'h0, 32'h0,         0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 32'h2, 0, 0, 32'h0, 32'h0,         0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h0010_0000, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 32'h0, 1, 0, 32'h6, 32'h0,         0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0,         0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 32'h4, 1, 0, 32'h0, 32'h0, 0, (i % 5) != 4, (i % 5) == 4, 1, 0, 1));
    vecs.push_back(mk(1, 32'h0, 1, 0, 32'h0, 32'h0,         0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 32'h0, 1, 0, 32'h0, 32'h0,         0, 1, 0, 1, 0, 1));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef IMEM_ARB_STATS_EN
    chk("stats stall p1", 32'(stall_cnt), 32'(exp_stall));
    chk("stats lgnt p1", 32'(lgnt_cnt), 32'(exp_lgnt));
`endif

    // Reset asserted in the cycle after a grant: the pending response must vanish.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("mid-rst f_rvalid", 32'(bus.o_f_rvalid), 32'd0);
    chk("mid-rst l_rvalid", 32'(bus.o_l_rvalid), 32'd0);
    chk("mid-rst f_instr", bus.o_f_instr, 32'd0);
    f_q.delete();
    l_q.delete();
    exp_stall = 0;
    exp_lgnt = 0;
    @(negedge clk);
    chk("mid-rst run", 32'(bus.o_run), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Phase 2: back in BOOT, boot pulse, starvation pattern from a cleared counter.
    vecs.delete();
    vecs.push_back(mk(1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 32'h4, 1, 0, 32'h4, 32'h0, 0, i != 4, i == 4, 1, 0, 1));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 100 + i);

`ifdef IMEM_ARB_STATS_EN
    chk("stats stall p2", 32'(stall_cnt), 32'(exp_stall));
    chk("stats lgnt p2", 32'(lgnt_cnt), 32'(exp_lgnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
